// File: rtl/axi4_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_arbiter
// Purpose  : Shares one AXI4-Lite master port between two requesters
//            (0 = IFU instruction fetch, 1 = LSU load/store). Round-robin
//            arbitration, one outstanding transaction at a time. Runs the
//            full AR->R read or AW+W->B write handshake for the granted
//            requester and returns data/response with a one-cycle done pulse.
// Ports    : iClock, iReset          - clock, synchronous active-high reset
//            iReqValid/Write [1:0]   - per-requester request valid / write flag
//            iReqAddr/Data/Mask      - per-requester payload, slice i = req i
//            oReqDone [1:0]          - one-cycle completion pulse per requester
//            oRspData, oRspResp      - read data / R or B response, valid
//                                      while oReqDone != 0, held afterwards
//            pAXI4_*                 - AXI4-Lite master (AR, R, AW, W, B)
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int RESP_WIDTH = 2
) (
  input  logic                    iClock,
  input  logic                    iReset,
  // requester side
  input  logic [1:0]              iReqValid,
  input  logic [1:0]              iReqWrite,
  input  logic [2*ADDR_WIDTH-1:0] iReqAddr,
  input  logic [2*DATA_WIDTH-1:0] iReqData,
  input  logic [2*MASK_WIDTH-1:0] iReqMask,
  output logic [1:0]              oReqDone,
  output logic [DATA_WIDTH-1:0]   oRspData,
  output logic [RESP_WIDTH-1:0]   oRspResp,
  // AXI4-Lite master side
  input  logic                    pAXI4_ar_ready,
  output logic                    pAXI4_ar_valid,
  output logic [ADDR_WIDTH-1:0]   pAXI4_ar_bits_addr,
  input  logic                    pAXI4_r_valid,
  input  logic [DATA_WIDTH-1:0]   pAXI4_r_bits_data,
  input  logic [RESP_WIDTH-1:0]   pAXI4_r_bits_resp,
  output logic                    pAXI4_r_ready,
  input  logic                    pAXI4_aw_ready,
  output logic                    pAXI4_aw_valid,
  output logic [ADDR_WIDTH-1:0]   pAXI4_aw_bits_addr,
  input  logic                    pAXI4_w_ready,
  output logic                    pAXI4_w_valid,
  output logic [DATA_WIDTH-1:0]   pAXI4_w_bits_data,
  output logic [MASK_WIDTH-1:0]   pAXI4_w_bits_strb,
  input  logic                    pAXI4_b_valid,
  input  logic [RESP_WIDTH-1:0]   pAXI4_b_bits_resp,
  output logic                    pAXI4_b_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  r_state;
  logic                    r_prio;    // requester favoured when both are valid
  logic                    r_grant;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [MASK_WIDTH-1:0]   r_mask;
  logic                    r_ar_valid;
  logic                    r_r_ready;
  logic                    r_aw_valid;
  logic                    r_w_valid;
  logic                    r_b_ready;
  logic [1:0]              r_done;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [RESP_WIDTH-1:0]   r_rsp_resp;

  logic                    w_any_req;
  logic                    w_grant_idx;
  logic                    w_grant_write;
  logic [ADDR_WIDTH-1:0]   w_grant_addr;
  logic [DATA_WIDTH-1:0]   w_grant_data;
  logic [MASK_WIDTH-1:0]   w_grant_mask;
  logic                    w_aw_clear;
  logic                    w_w_clear;

  // Round-robin pick: a lone requester wins outright, a tie goes to r_prio.
  always_comb begin
    w_any_req   = |iReqValid;
    w_grant_idx = (&iReqValid) ? r_prio : iReqValid[1];
    if (w_grant_idx) begin
      w_grant_write = iReqWrite[1];
      w_grant_addr  = iReqAddr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      w_grant_data  = iReqData[2*DATA_WIDTH-1:DATA_WIDTH];
      w_grant_mask  = iReqMask[2*MASK_WIDTH-1:MASK_WIDTH];
    end else begin
      w_grant_write = iReqWrite[0];
      w_grant_addr  = iReqAddr[ADDR_WIDTH-1:0];
      w_grant_data  = iReqData[DATA_WIDTH-1:0];
      w_grant_mask  = iReqMask[MASK_WIDTH-1:0];
    end
  end

  // A write channel counts as finished if its valid already dropped or it
  // handshakes this cycle; AW and W may complete in either order.
  assign w_aw_clear = !r_aw_valid || pAXI4_aw_ready;
  assign w_w_clear  = !r_w_valid  || pAXI4_w_ready;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_done     <= 2'b00;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_grant_idx;
            r_prio  <= ~w_grant_idx;
            r_addr  <= w_grant_addr;
            r_data  <= w_grant_data;
            r_mask  <= w_grant_mask;
            if (w_grant_write) begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_state    <= S_WR_REQ;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (pAXI4_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (pAXI4_r_valid) begin
            r_r_ready  <= 1'b0;
            r_rsp_data <= pAXI4_r_bits_data;
            r_rsp_resp <= pAXI4_r_bits_resp;
            r_done     <= r_grant ? 2'b10 : 2'b01;
            r_state    <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (r_aw_valid && pAXI4_aw_ready) r_aw_valid <= 1'b0;
          if (r_w_valid  && pAXI4_w_ready)  r_w_valid  <= 1'b0;
          if (w_aw_clear && w_w_clear) begin
            r_b_ready <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (pAXI4_b_valid) begin
            r_b_ready  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_resp <= pAXI4_b_bits_resp;
            r_done     <= r_grant ? 2'b10 : 2'b01;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          // r_done falls back to zero here, giving a single-cycle pulse.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oReqDone           = r_done;
  assign oRspData           = r_rsp_data;
  assign oRspResp           = r_rsp_resp;
  assign pAXI4_ar_valid     = r_ar_valid;
  assign pAXI4_ar_bits_addr = r_addr;
  assign pAXI4_r_ready      = r_r_ready;
  assign pAXI4_aw_valid     = r_aw_valid;
  assign pAXI4_aw_bits_addr = r_addr;
  assign pAXI4_w_valid      = r_w_valid;
  assign pAXI4_w_bits_data  = r_data;
  assign pAXI4_w_bits_strb  = r_mask;
  assign pAXI4_b_ready      = r_b_ready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi4_lite_arbiter
// Purpose  : Directed self-checking bench for axi4_lite_arbiter with a small
//            AXI4-Lite slave model whose per-channel wait states are set by
//            each scenario task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int RW = 2;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  always #5 iClock = ~iClock;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_data  = '0;
  logic [2*MW-1:0] req_mask  = '0;
  logic [1:0]      done;
  logic [DW-1:0]   rsp_data;
  logic [RW-1:0]   rsp_resp;

  logic ar_ready, ar_valid, r_valid, r_ready, aw_ready, aw_valid;
  logic w_ready, w_valid, b_valid, b_ready;
  logic [AW-1:0] ar_addr, aw_addr;
  logic [DW-1:0] w_data;
  logic [MW-1:0] w_strb;

  // slave model configuration and state
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [DW-1:0] s_rdata = '0;
  logic [RW-1:0] s_rresp = '0;
  logic [RW-1:0] s_bresp = '0;
  logic rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  axi4_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RESP_WIDTH(RW)) dut (
    .iClock(iClock), .iReset(iReset),
    .iReqValid(req_valid), .iReqWrite(req_write), .iReqAddr(req_addr),
    .iReqData(req_data), .iReqMask(req_mask),
    .oReqDone(done), .oRspData(rsp_data), .oRspResp(rsp_resp),
    .pAXI4_ar_ready(ar_ready), .pAXI4_ar_valid(ar_valid), .pAXI4_ar_bits_addr(ar_addr),
    .pAXI4_r_valid(r_valid), .pAXI4_r_bits_data(s_rdata), .pAXI4_r_bits_resp(s_rresp),
    .pAXI4_r_ready(r_ready),
    .pAXI4_aw_ready(aw_ready), .pAXI4_aw_valid(aw_valid), .pAXI4_aw_bits_addr(aw_addr),
    .pAXI4_w_ready(w_ready), .pAXI4_w_valid(w_valid), .pAXI4_w_bits_data(w_data),
    .pAXI4_w_bits_strb(w_strb),
    .pAXI4_b_valid(b_valid), .pAXI4_b_bits_resp(s_bresp), .pAXI4_b_ready(b_ready)
  );

  // Slave: readies/valids rise once the matching counter reaches its wait.
  assign ar_ready = ar_valid && (ar_cnt >= ar_wait);
  assign r_valid  = rd_pend && (r_cnt >= r_wait);
  assign aw_ready = aw_valid && (aw_cnt >= aw_wait);
  assign w_ready  = w_valid && (w_cnt >= w_wait);
  assign b_valid  = aw_got && w_got && (b_cnt >= b_wait);

  always @(posedge iClock) begin
    if (iReset) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      ar_cnt <= (ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
      r_cnt  <= (rd_pend && !r_valid) ? r_cnt + 1 : 0;
      aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
      w_cnt  <= (w_valid && !w_ready) ? w_cnt + 1 : 0;
      b_cnt  <= (aw_got && w_got && !b_valid) ? b_cnt + 1 : 0;
      if (ar_valid && ar_ready) rd_pend <= 1'b1;
      else if (r_valid && r_ready) rd_pend <= 1'b0;
      if (aw_valid && aw_ready) aw_got <= 1'b1;
      if (w_valid && w_ready) w_got <= 1'b1;
      if (b_valid && b_ready) begin aw_got <= 1'b0; w_got <= 1'b0; end
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    req_valid = 2'b00;
    repeat (3) tick();
    n_total++; if ({ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 5'b0) $display("FAIL reset_valids: got %b exp 00000", {ar_valid, r_ready, aw_valid, w_valid, b_ready}); else n_pass++;
    n_total++; if (ar_addr !== 32'h0) $display("FAIL reset_ar_addr: got %h exp 0", ar_addr); else n_pass++;
    n_total++; if (aw_addr !== 32'h0) $display("FAIL reset_aw_addr: got %h exp 0", aw_addr); else n_pass++;
    n_total++; if ({w_data, w_strb} !== 36'h0) $display("FAIL reset_w_bits: got %h exp 0", {w_data, w_strb}); else n_pass++;
    n_total++; if (done !== 2'b00) $display("FAIL reset_done: got %b exp 00", done); else n_pass++;
    n_total++; if ({rsp_data, rsp_resp} !== 34'h0) $display("FAIL reset_rsp: got %h exp 0", {rsp_data, rsp_resp}); else n_pass++;
    iReset = 1'b0;
  endtask

  task automatic test_read_basic();
    req_valid = 2'b01; req_write = 2'b00; req_addr[AW-1:0] = 32'h8000_0000;
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    tick(); // cycle 1
    n_total++; if ({ar_valid, ar_addr} !== {1'b1, 32'h8000_0000}) $display("FAIL rd_c1_ar: got %b/%h exp 1/80000000", ar_valid, ar_addr); else n_pass++;
    tick(); // cycle 2
    n_total++; if ({ar_valid, r_ready, done} !== 4'b0100) $display("FAIL rd_c2: got %b exp 0100", {ar_valid, r_ready, done}); else n_pass++;
    tick(); // cycle 3
    n_total++; if (done !== 2'b01) $display("FAIL rd_c3_done: got %b exp 01", done); else n_pass++;
    n_total++; if ({rsp_data, rsp_resp} !== {32'hDEAD_BEEF, 2'b00}) $display("FAIL rd_c3_rsp: got %h/%b exp deadbeef/00", rsp_data, rsp_resp); else n_pass++;
    req_valid = 2'b00;
    tick(); // cycle 4
    n_total++; if ({done, rsp_data} !== {2'b00, 32'hDEAD_BEEF}) $display("FAIL rd_c4_hold: got %b/%h exp 00/deadbeef", done, rsp_data); else n_pass++;
  endtask

  task automatic test_write();
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[2*AW-1:AW] = 32'h8000_0010; req_data[2*DW-1:DW] = 32'h1234_5678; req_mask[2*MW-1:MW] = 4'h3;
    aw_wait = 0; w_wait = 2; b_wait = 0; s_bresp = 2'b00;
    tick(); // cycle 1
    n_total++; if ({aw_valid, w_valid} !== 2'b11) $display("FAIL wr_c1_valids: got %b exp 11", {aw_valid, w_valid}); else n_pass++;
    n_total++; if ({aw_addr, w_data, w_strb} !== {32'h8000_0010, 32'h1234_5678, 4'h3}) $display("FAIL wr_c1_bits: got %h/%h/%h exp 80000010/12345678/3", aw_addr, w_data, w_strb); else n_pass++;
    tick(); // cycle 2
    n_total++; if ({aw_valid, w_valid} !== 2'b01) $display("FAIL wr_c2_valids: got %b exp 01", {aw_valid, w_valid}); else n_pass++;
    tick(); // cycle 3
    n_total++; if ({aw_valid, w_valid, b_ready} !== 3'b010) $display("FAIL wr_c3_valids: got %b exp 010", {aw_valid, w_valid, b_ready}); else n_pass++;
    tick(); // cycle 4
    n_total++; if ({w_valid, b_ready, done} !== 4'b0100) $display("FAIL wr_c4_bready: got %b exp 0100", {w_valid, b_ready, done}); else n_pass++;
    tick(); // cycle 5
    n_total++; if ({done, rsp_data, rsp_resp} !== {2'b10, 32'h0, 2'b00}) $display("FAIL wr_c5_done: got %b/%h/%b exp 10/0/00", done, rsp_data, rsp_resp); else n_pass++;
    req_valid = 2'b00; w_wait = 0;
    tick();
    n_total++; if (done !== 2'b00) $display("FAIL wr_c6_pulse: got %b exp 00", done); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    int t;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    iReset = 1'b1;
    repeat (2) tick();
    iReset = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    s_rdata = 32'h55AA_55AA; s_rresp = 2'b00;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (done === 2'b00 && t < 20) begin tick(); t++; end
      n_total++; if (done !== exp_g[k]) $display("FAIL rr_grant%0d: got %b exp %b", k, done, exp_g[k]); else n_pass++;
      if (k == 3) req_valid = 2'b00;
      tick();
      n_total++; if (done !== 2'b00) $display("FAIL rr_pulse%0d: got %b exp 00", k, done); else n_pass++;
    end
    tick();
  endtask

  task automatic test_stall();
    req_valid = 2'b01; req_write = 2'b00; req_addr[AW-1:0] = 32'h8000_0040;
    ar_wait = 5; r_wait = 3; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_total++; if ({ar_valid, done} !== {(c <= 6), 2'b00}) $display("FAIL stall_c%0d: got %b exp %b", c, {ar_valid, done}, {(c <= 6), 2'b00}); else n_pass++;
      if (c <= 6) begin
        n_total++; if (ar_addr !== 32'h8000_0040) $display("FAIL stall_addr_c%0d: got %h exp 80000040", c, ar_addr); else n_pass++;
      end
    end
    tick(); // cycle 11
    n_total++; if ({done, rsp_data} !== {2'b01, 32'hCAFE_F00D}) $display("FAIL stall_done: got %b/%h exp 01/cafef00d", done, rsp_data); else n_pass++;
    req_valid = 2'b00; ar_wait = 0; r_wait = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_write = 2'b00; req_addr[AW-1:0] = 32'h8000_0080; r_wait = 10;
    tick(); tick(); // RD_DATA
    n_total++; if (r_ready !== 1'b1) $display("FAIL rstmid_rready: got %b exp 1", r_ready); else n_pass++;
    iReset = 1'b1;
    tick();
    n_total++; if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, done} !== 7'b0) $display("FAIL rstmid_ctrl: got %b exp 0", {ar_valid, r_ready, aw_valid, w_valid, b_ready, done}); else n_pass++;
    n_total++; if ({ar_addr, rsp_data, rsp_resp} !== 66'h0) $display("FAIL rstmid_data: got %h exp 0", {ar_addr, rsp_data, rsp_resp}); else n_pass++;
    iReset = 1'b0; req_valid = 2'b00; r_wait = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if ({done, ar_valid, r_ready} !== 4'b0) $display("FAIL rstmid_quiet%0d: got %b exp 0000", c, {done, ar_valid, r_ready}); else n_pass++;
    end
    req_valid = 2'b11; req_addr = {32'h8000_0300, 32'h8000_0100}; s_rdata = 32'h1357_9BDF;
    tick();
    n_total++; if ({ar_valid, ar_addr} !== {1'b1, 32'h8000_0100}) $display("FAIL rstmid_regrant: got %b/%h exp 1/80000100", ar_valid, ar_addr); else n_pass++;
    tick(); tick();
    n_total++; if ({done, rsp_data} !== {2'b01, 32'h1357_9BDF}) $display("FAIL rstmid_done: got %b/%h exp 01/13579bdf", done, rsp_data); else n_pass++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_error_resp();
    req_valid = 2'b01; req_write = 2'b00; req_addr[AW-1:0] = 32'h8000_0200;
    s_rdata = 32'h0BAD_F00D; s_rresp = 2'b10;
    tick(); tick(); tick();
    n_total++; if ({done, rsp_resp, rsp_data} !== {2'b01, 2'b10, 32'h0BAD_F00D}) $display("FAIL err_rd: got %b/%b/%h exp 01/10/0badf00d", done, rsp_resp, rsp_data); else n_pass++;
    req_valid = 2'b00;
    tick();
    n_total++; if ({done, ar_valid, r_ready} !== 4'b0) $display("FAIL err_idle: got %b exp 0000", {done, ar_valid, r_ready}); else n_pass++;
    req_valid = 2'b10; req_write = 2'b10; s_bresp = 2'b11;
    tick(); tick(); tick();
    n_total++; if ({done, rsp_resp, rsp_data} !== {2'b10, 2'b11, 32'h0}) $display("FAIL err_wr: got %b/%b/%h exp 10/11/0", done, rsp_resp, rsp_data); else n_pass++;
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_error_resp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi4_lite_arbiter.md
Name: axi4_lite_arbiter

Overview:
- Shares one AXI4-Lite master port between two requesters: requester 0 is IFU instruction fetch, requester 1 is LSU load/store.
- Sits between the IFU/LSU and the downstream AXI4-Lite slave (SRAM/UART crossbar).
- Round-robin arbitration, one outstanding transaction at a time.
- Sequences the full read (AR→R) and write (AW+W→B) handshakes and returns data and response to the granted requester.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MASK_WIDTH, 4, write strobe width (DATA_WIDTH/8)
RESP_WIDTH, 2, AXI response width

Ports:
iClock  in  1  clock; single clock domain
iReset  in  1  reset; synchronous, active-high
iReqValid  in  2  bit i = requester i has a pending request
iReqWrite  in  2  bit i: 1 = write, 0 = read
iReqAddr  in  2*ADDR_WIDTH  slice i = address of requester i
iReqData  in  2*DATA_WIDTH  slice i = write data
iReqMask  in  2*MASK_WIDTH  slice i = write strobe
oReqDone  out  2  one-cycle pulse on bit i when requester i's transaction completes
oRspData  out  DATA_WIDTH  read data; valid while oReqDone != 0
oRspResp  out  RESP_WIDTH  R or B response; valid while oReqDone != 0
pAXI4_ar_ready  in  1  slave read-address ready
pAXI4_ar_valid  out  1  read-address valid
pAXI4_ar_bits_addr  out  ADDR_WIDTH  read address
pAXI4_r_valid  in  1  read-data valid
pAXI4_r_bits_data  in  DATA_WIDTH  read data
pAXI4_r_bits_resp  in  RESP_WIDTH  read response
pAXI4_r_ready  out  1  read-data ready
pAXI4_aw_ready  in  1  write-address ready
pAXI4_aw_valid  out  1  write-address valid
pAXI4_aw_bits_addr  out  ADDR_WIDTH  write address
pAXI4_w_ready  in  1  write-data ready
pAXI4_w_valid  out  1  write-data valid
pAXI4_w_bits_data  out  DATA_WIDTH  write data
pAXI4_w_bits_strb  out  MASK_WIDTH  write strobe
pAXI4_b_valid  in  1  write-response valid
pAXI4_b_bits_resp  in  RESP_WIDTH  write response
pAXI4_b_ready  out  1  write-response ready

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and the round-robin pointer is set to favour requester 0.
  - All outputs are 0: valids, readies, addresses, data, strobes, oReqDone, oRspData, oRspResp.
  - Reset mid-transaction abandons the transaction; no done pulse is issued. The slave is reset together with the arbiter.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester the pointer favours. On each grant the pointer is set to favour the other requester.
  - On grant, register the grant index plus that requester's write, address, data and mask into internal latches.
  - Next state is WR_REQ if write, RD_ADDR if read. No request means stay in IDLE.
- RD_ADDR: ar_valid = 1, ar_addr = latched address. On ar_valid && ar_ready, go to RD_DATA and drop ar_valid.
- RD_DATA: r_ready = 1. On r_valid && r_ready, capture r data and resp into the response registers and go to DONE.
- WR_REQ:
  - aw_valid and w_valid assert together in the first WR_REQ cycle.
  - Each valid deasserts independently after its own handshake; either order is legal, same cycle is legal.
  - Once both handshakes are done, go to WR_RESP.
- WR_RESP: b_ready = 1. On b handshake, capture b_resp (oRspData = 0) and go to DONE.
- DONE:
  - oReqDone[grant] = 1 for exactly one cycle, with oRspData/oRspResp valid in that cycle. Then go to IDLE.
  - oRspData/oRspResp hold their value until the next completion.
- Latency with a zero-wait slave: request seen in IDLE at cycle 0 gives oReqDone at cycle 3. Re-arbitration happens at the earliest in the cycle after DONE.
- Requester rules:
  - A requester holds valid and payload stable until its done pulse, then drops valid or presents the next request.
  - The arbiter uses only latched payload after grant. Payload changes or valid drops after grant do not affect the transaction.
- Requests arriving while busy wait; no queueing beyond the level-held valid.
- Error responses (SLVERR/DECERR) pass through unchanged; no retry.
- Address and data outputs hold their latched values outside their valid phases.

Test Plan:
- Read, requester 0, addr 0x8000_0000, slave zero-wait returns 0xDEAD_BEEF with resp 0 → ar_addr 0x8000_0000 at cycle 1, oReqDone = 2'b01 at cycle 3, oRspData 0xDEAD_BEEF.
- Write, requester 1, addr 0x8000_0010, data 0x1234_5678, mask 0x3; slave takes AW at cycle 1 and W at cycle 3 → aw_valid drops after cycle 1, w_valid stays high until cycle 3, B handled, oReqDone = 2'b10, strb 0x3.
- Both requesters valid continuously after reset → grants alternate 0, 1, 0, 1 across 4 transactions, each done pulse one cycle wide.
- Slave holds ar_ready low for 5 cycles and r_valid for 3 more → ar_valid stays high and stable until the handshake, no done pulse before r_valid, data captured correctly.
- Reset asserted during RD_DATA → next cycle all outputs 0, no oReqDone. A new read after reset completes normally with requester 0 favoured.
- Read returns resp 2'b10 → oRspResp = 2'b10 on the done pulse; arbiter returns to IDLE.
